// File: rtl/ctrl_seq_if.sv
// Control-sequencer port bundle: fetch/decode inputs toward the sequencer,
// bus select, control strobes and status back out of it.
interface ctrl_seq_if #(parameter int OP_W = 4);
    logic            run;
    logic [OP_W-1:0] opcode;
    logic            zf;
    logic            cf;
    logic [2:0]      bus_sel;
    logic            pc_inc;
    logic            pc_load;
    logic            mar_load;
    logic            ram_rd;
    logic            ram_wr;
    logic            ir_load;
    logic            a_load;
    logic            b_load;
    logic            out_load;
    logic            flags_load;
    logic            alu_sub;
    logic [2:0]      tstate;
    logic            halted;

    modport master (
        output run, opcode, zf, cf,
        input  bus_sel, pc_inc, pc_load, mar_load, ram_rd, ram_wr, ir_load,
               a_load, b_load, out_load, flags_load, alu_sub, tstate, halted
    );

    modport slave (
        input  run, opcode, zf, cf,
        output bus_sel, pc_inc, pc_load, mar_load, ram_rd, ram_wr, ir_load,
               a_load, b_load, out_load, flags_load, alu_sub, tstate, halted
    );
endinterface

// File: rtl/ctrl_seq.sv
// T-state microsequencer for a small accumulator CPU: T0..T4 plus HALT,
// with all strobes decoded combinationally from state, opcode and flags.
module ctrl_seq #(
    parameter int OP_W = 4
) (
    input  logic     clk,
    input  logic     rst,
    ctrl_seq_if.slave cs
);
    localparam logic [2:0] ST_T0   = 3'd0;
    localparam logic [2:0] ST_T1   = 3'd1;
    localparam logic [2:0] ST_T2   = 3'd2;
    localparam logic [2:0] ST_T3   = 3'd3;
    localparam logic [2:0] ST_T4   = 3'd4;
    localparam logic [2:0] ST_HALT = 3'd5;

    localparam logic [2:0] BUS_NONE = 3'd0;
    localparam logic [2:0] BUS_PC   = 3'd1;
    localparam logic [2:0] BUS_IR   = 3'd2;
    localparam logic [2:0] BUS_RAM  = 3'd3;
    localparam logic [2:0] BUS_A    = 3'd4;
    localparam logic [2:0] BUS_ALU  = 3'd5;

    localparam logic [OP_W-1:0] OP_LDA = OP_W'(1);
    localparam logic [OP_W-1:0] OP_ADD = OP_W'(2);
    localparam logic [OP_W-1:0] OP_SUB = OP_W'(3);
    localparam logic [OP_W-1:0] OP_STA = OP_W'(4);
    localparam logic [OP_W-1:0] OP_LDI = OP_W'(5);
    localparam logic [OP_W-1:0] OP_JMP = OP_W'(6);
    localparam logic [OP_W-1:0] OP_JC  = OP_W'(7);
    localparam logic [OP_W-1:0] OP_JZ  = OP_W'(8);
    localparam logic [OP_W-1:0] OP_OUT = OP_W'(14);
    localparam logic [OP_W-1:0] OP_HLT = OP_W'(15);

    logic [2:0] state_q, state_d;
    logic [2:0] bus_sel;
    logic pc_inc, pc_load, mar_load, ram_rd, ram_wr, ir_load;
    logic a_load, b_load, out_load, flags_load, alu_sub;

    always_comb begin
        state_d    = state_q;
        bus_sel    = BUS_NONE;
        pc_inc     = 1'b0;
        pc_load    = 1'b0;
        mar_load   = 1'b0;
        ram_rd     = 1'b0;
        ram_wr     = 1'b0;
        ir_load    = 1'b0;
        a_load     = 1'b0;
        b_load     = 1'b0;
        out_load   = 1'b0;
        flags_load = 1'b0;
        alu_sub    = 1'b0;
        case (state_q)
            ST_T0: begin
                if (cs.run) begin
                    mar_load = 1'b1;
                    bus_sel  = BUS_PC;
                    state_d  = ST_T1;
                end
            end
            ST_T1: begin
                ram_rd  = 1'b1;
                ir_load = 1'b1;
                pc_inc  = 1'b1;
                bus_sel = BUS_RAM;
                state_d = ST_T2;
            end
            ST_T2: begin
                state_d = ST_T0;
                case (cs.opcode)
                    OP_LDA, OP_ADD, OP_SUB, OP_STA: begin
                        mar_load = 1'b1;
                        bus_sel  = BUS_IR;
                        state_d  = ST_T3;
                    end
                    OP_LDI: begin
                        a_load  = 1'b1;
                        bus_sel = BUS_IR;
                    end
                    OP_JMP: begin
                        pc_load = 1'b1;
                        bus_sel = BUS_IR;
                    end
                    // Not-taken jumps leave the bus idle so nothing drives it pointlessly.
                    OP_JC: begin
                        pc_load = cs.cf;
                        bus_sel = cs.cf ? BUS_IR : BUS_NONE;
                    end
                    OP_JZ: begin
                        pc_load = cs.zf;
                        bus_sel = cs.zf ? BUS_IR : BUS_NONE;
                    end
                    OP_OUT: begin
                        out_load = 1'b1;
                        bus_sel  = BUS_A;
                    end
                    OP_HLT:  state_d = ST_HALT;
                    default: state_d = ST_T0;
                endcase
            end
            ST_T3: begin
                state_d = ST_T0;
                case (cs.opcode)
                    OP_LDA: begin
                        ram_rd  = 1'b1;
                        a_load  = 1'b1;
                        bus_sel = BUS_RAM;
                    end
                    OP_ADD, OP_SUB: begin
                        ram_rd  = 1'b1;
                        b_load  = 1'b1;
                        bus_sel = BUS_RAM;
                        state_d = ST_T4;
                    end
                    OP_STA: begin
                        ram_wr  = 1'b1;
                        bus_sel = BUS_A;
                    end
                    default: state_d = ST_T0;
                endcase
            end
            ST_T4: begin
                state_d = ST_T0;
                if (cs.opcode == OP_ADD || cs.opcode == OP_SUB) begin
                    a_load     = 1'b1;
                    flags_load = 1'b1;
                    alu_sub    = (cs.opcode == OP_SUB);
                    bus_sel    = BUS_ALU;
                end
            end
            ST_HALT: state_d = ST_HALT;
            default: state_d = ST_T0;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= ST_T0;
        else     state_q <= state_d;
    end

    // Reset gates the decode directly so strobes drop without waiting for a clock.
    assign cs.bus_sel    = rst ? BUS_NONE : bus_sel;
    assign cs.pc_inc     = pc_inc     & ~rst;
    assign cs.pc_load    = pc_load    & ~rst;
    assign cs.mar_load   = mar_load   & ~rst;
    assign cs.ram_rd     = ram_rd     & ~rst;
    assign cs.ram_wr     = ram_wr     & ~rst;
    assign cs.ir_load    = ir_load    & ~rst;
    assign cs.a_load     = a_load     & ~rst;
    assign cs.b_load     = b_load     & ~rst;
    assign cs.out_load   = out_load   & ~rst;
    assign cs.flags_load = flags_load & ~rst;
    assign cs.alu_sub    = alu_sub    & ~rst;
    assign cs.halted     = (state_q == ST_HALT);
    assign cs.tstate     = (state_q == ST_HALT) ? ST_T0 : state_q;
endmodule

// File: tb/tb_ctrl_seq.sv
// Bench for ctrl_seq: per-instruction cycle-list model checked every cycle,
// plus directed literal expectations for each instruction class.
module tb_ctrl_seq;
    typedef struct packed {
        logic [2:0]  ts;
        logic        hlt;
        logic [2:0]  bs;
        logic [10:0] stb;
    } vec_t;

    localparam logic [10:0] PCI  = 11'h001;
    localparam logic [10:0] PCL  = 11'h002;
    localparam logic [10:0] MAR  = 11'h004;
    localparam logic [10:0] RD   = 11'h008;
    localparam logic [10:0] WR   = 11'h010;
    localparam logic [10:0] IR   = 11'h020;
    localparam logic [10:0] AL   = 11'h040;
    localparam logic [10:0] BL   = 11'h080;
    localparam logic [10:0] OUTL = 11'h100;
    localparam logic [10:0] FL   = 11'h200;
    localparam logic [10:0] SUBS = 11'h400;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int total = 0;
    int bad   = 0;

    ctrl_seq_if #(.OP_W(4)) cif();
    ctrl_seq #(.OP_W(4)) dut (.clk(clk), .rst(rst), .cs(cif));

    always #5 clk = ~clk;

    vec_t m_q[$];
    bit   m_need_exec = 1'b0;
    bit   m_halt_pend = 1'b0;
    bit   m_halt      = 1'b0;

    function automatic vec_t mk(int ts, int bs, logic [10:0] s);
        vec_t v;
        v.ts  = 3'(ts);
        v.hlt = 1'b0;
        v.bs  = 3'(bs);
        v.stb = s;
        return v;
    endfunction

    function automatic vec_t act();
        vec_t v;
        v.ts  = cif.tstate;
        v.hlt = cif.halted;
        v.bs  = cif.bus_sel;
        v.stb = {cif.alu_sub, cif.flags_load, cif.out_load, cif.b_load, cif.a_load,
                 cif.ir_load, cif.ram_wr, cif.ram_rd, cif.mar_load, cif.pc_load, cif.pc_inc};
        return v;
    endfunction

    // Execute-phase cycle list for one opcode, evaluated once the opcode is valid.
    function automatic void build_exec(logic [3:0] op, logic z, logic c);
        case (op)
            4'h1: begin m_q.push_back(mk(2,2,MAR)); m_q.push_back(mk(3,3,RD|AL)); end
            4'h2: begin m_q.push_back(mk(2,2,MAR)); m_q.push_back(mk(3,3,RD|BL));
                        m_q.push_back(mk(4,5,AL|FL)); end
            4'h3: begin m_q.push_back(mk(2,2,MAR)); m_q.push_back(mk(3,3,RD|BL));
                        m_q.push_back(mk(4,5,AL|FL|SUBS)); end
            4'h4: begin m_q.push_back(mk(2,2,MAR)); m_q.push_back(mk(3,4,WR)); end
            4'h5: m_q.push_back(mk(2,2,AL));
            4'h6: m_q.push_back(mk(2,2,PCL));
            4'h7: m_q.push_back(c ? mk(2,2,PCL) : mk(2,0,0));
            4'h8: m_q.push_back(z ? mk(2,2,PCL) : mk(2,0,0));
            4'hE: m_q.push_back(mk(2,4,OUTL));
            4'hF: begin m_q.push_back(mk(2,0,0)); m_halt_pend = 1'b1; end
            default: m_q.push_back(mk(2,0,0));
        endcase
    endfunction

    always @(negedge clk) begin
        vec_t e;
        vec_t a;
        if (rst) begin
            m_q.delete();
            m_need_exec = 1'b0;
            m_halt_pend = 1'b0;
            m_halt      = 1'b0;
            e = '0;
        end else if (m_halt) begin
            e = '0;
            e.hlt = 1'b1;
        end else begin
            if (m_q.size() == 0 && m_need_exec) begin
                build_exec(cif.opcode, cif.zf, cif.cf);
                m_need_exec = 1'b0;
            end else if (m_q.size() == 0 && cif.run) begin
                m_q.push_back(mk(0,1,MAR));
                m_q.push_back(mk(1,3,RD|IR|PCI));
                m_need_exec = 1'b1;
            end
            if (m_q.size() == 0) e = '0;
            else begin
                e = m_q.pop_front();
                if (m_q.size() == 0 && !m_need_exec && m_halt_pend) m_halt = 1'b1;
            end
        end
        a = act();
        total++;
        if (a !== e) begin
            bad++;
            $display("FAIL model t=%0t got ts=%0d h=%0d bs=%0d stb=%h want ts=%0d h=%0d bs=%0d stb=%h",
                     $time, a.ts, a.hlt, a.bs, a.stb, e.ts, e.hlt, e.bs, e.stb);
        end
        total++;
        if ((cif.ram_rd & cif.ram_wr) || cif.bus_sel > 3'd5) begin
            bad++;
            $display("FAIL excl t=%0t got rd=%0d wr=%0d bs=%0d want rd&wr=0 bs<=5",
                     $time, cif.ram_rd, cif.ram_wr, cif.bus_sel);
        end
    end

    task automatic chk(string nm, logic [31:0] a, logic [31:0] e);
        total++;
        if (a !== e) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, a, e);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic exp_cyc(string nm, int ts, int bs, logic [10:0] s);
        @(negedge clk);
        chk(nm, 32'(act()), 32'(mk(ts, bs, s)));
        tick();
    endtask

    task automatic fetch(logic [3:0] op, logic z, logic c);
        cif.opcode = op;
        cif.zf     = z;
        cif.cf     = c;
        cif.run    = 1'b1;
        exp_cyc("fetch_t0", 0, 1, MAR);
        exp_cyc("fetch_t1", 1, 3, RD|IR|PCI);
    endtask

    task automatic run_instr(logic [3:0] op, logic z, logic c, int n);
        cif.opcode = op;
        cif.zf     = z;
        cif.cf     = c;
        cif.run    = 1'b1;
        repeat (n) tick();
    endtask

    initial begin
        cif.run = 1'b1; cif.opcode = 4'h0; cif.zf = 1'b0; cif.cf = 1'b0;
        repeat (2) tick();
        exp_cyc("rst_gate", 0, 0, 0);

        cif.run = 1'b0;
        rst = 1'b0;
        repeat (3) exp_cyc("idle_norun", 0, 0, 0);

        fetch(4'h5, 0, 0); exp_cyc("ldi_t2", 2, 2, AL);
        fetch(4'h2, 0, 0); exp_cyc("add_t2", 2, 2, MAR);
        exp_cyc("add_t3", 3, 3, RD|BL); exp_cyc("add_t4", 4, 5, AL|FL);
        fetch(4'h3, 0, 0); exp_cyc("sub_t2", 2, 2, MAR);
        exp_cyc("sub_t3", 3, 3, RD|BL); exp_cyc("sub_t4", 4, 5, AL|FL|SUBS);
        fetch(4'h8, 0, 0); exp_cyc("jz0_t2", 2, 0, 0);
        fetch(4'h8, 1, 0); exp_cyc("jz1_t2", 2, 2, PCL);

        // Flags move between fetch and T2: the T2 value must decide the jump.
        cif.opcode = 4'h7; cif.cf = 1'b0; cif.run = 1'b1;
        tick(); tick();
        cif.cf = 1'b1;
        exp_cyc("jc_late_flag", 2, 2, PCL);

        run_instr(4'h1, 0, 0, 4);
        run_instr(4'h4, 0, 0, 4);
        run_instr(4'h6, 0, 0, 3);
        run_instr(4'h7, 0, 0, 3);
        run_instr(4'hE, 0, 0, 3);
        run_instr(4'h0, 0, 0, 3);
        run_instr(4'h9, 1, 1, 3);
        run_instr(4'hC, 0, 1, 3);

        fetch(4'h2, 0, 0); exp_cyc("drop_t2", 2, 2, MAR);
        cif.run = 1'b0;
        exp_cyc("drop_t3", 3, 3, RD|BL);
        exp_cyc("drop_t4", 4, 5, AL|FL);
        repeat (3) exp_cyc("drop_idle", 0, 0, 0);

        fetch(4'h4, 0, 0); exp_cyc("sta_t2", 2, 2, MAR);
        @(negedge clk);
        chk("sta_t3_wr", 32'(cif.ram_wr), 32'd1);
        #2 rst = 1'b1;
        #1;
        chk("sta_async_wr", 32'(cif.ram_wr), 32'd0);
        chk("sta_async_ts", 32'(cif.tstate), 32'd0);
        tick(); tick();
        rst = 1'b0;
        fetch(4'h5, 0, 0); exp_cyc("ldi_after_rst", 2, 2, AL);

        fetch(4'hF, 0, 0); exp_cyc("hlt_t2", 2, 0, 0);
        for (int i = 0; i < 22; i++) begin
            cif.run = 1'(i % 2);
            @(negedge clk);
            chk("halted_hold", 32'(cif.halted), 32'd1);
            tick();
        end
        rst = 1'b1;
        #1;
        chk("rst_clr_halt", 32'(cif.halted), 32'd0);
        chk("rst_clr_ts", 32'(cif.tstate), 32'd0);
        tick();
        cif.run = 1'b0;
        rst = 1'b0;
        repeat (2) tick();
        run_instr(4'h5, 0, 0, 3);
        cif.run = 1'b0;
        repeat (2) tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/ctrl_seq.md
CTRL_SEQ -- requirements
Module: ctrl_seq

Interface
REQ-001 The block SHALL have parameter OP_W, default 4, the opcode width taken from the instruction register high nibble.
REQ-002 Port clk SHALL be: clk  input  1  single system clock; all state updates on its rising edge.
REQ-003 Port rst SHALL be: rst  input  1  reset, asynchronous and active-high.
REQ-004 Port run SHALL be: run  input  1  enables instruction fetch at an instruction boundary.
REQ-005 Port opcode SHALL be: opcode  input  OP_W  current IR opcode; valid from T2 onward.
REQ-006 Ports zf and cf SHALL be: zf, cf  input  1 each  registered ALU zero and carry flags.
REQ-007 Port bus_sel SHALL be: bus_sel  output  3  bus driver select; 0 none, 1 PC, 2 IR operand, 3 RAM, 4 A, 5 ALU.
REQ-008 Load and strobe outputs SHALL be: pc_inc, pc_load, mar_load, ram_rd, ram_wr, ir_load, a_load, b_load, out_load, flags_load, alu_sub  output  1 each  control strobes.
REQ-009 Status outputs SHALL be: tstate  output  3  current T-state (0-4); halted  output  1  CPU stopped.

Function
REQ-010 The sequencer state SHALL be a registered T-state counter T0..T4 plus a registered HALT state.
REQ-011 All strobes and bus_sel SHALL be combinational decodes of the registered state, opcode, zf and cf; strobes not listed for a state SHALL be 0.
REQ-012 In T0 with run=1, the block SHALL assert mar_load with bus_sel=1 and advance to T1.
REQ-013 In T0 with run=0, the block SHALL hold T0 with all strobes 0 and bus_sel=0.
REQ-014 In T1, the block SHALL assert ram_rd, ir_load and pc_inc with bus_sel=3, then advance to T2.
REQ-015 Opcodes SHALL be: 0 NOP, 1 LDA, 2 ADD, 3 SUB, 4 STA, 5 LDI, 6 JMP, 7 JC, 8 JZ, E OUT, F HLT; codes 9-D SHALL behave as NOP.
REQ-016 T2 decode for LDA, ADD, SUB and STA SHALL be: mar_load with bus_sel=2, then go to T3.
REQ-017 T2 decode for LDI SHALL be: a_load with bus_sel=2, then go to T0.
REQ-018 T2 decode for JMP SHALL be: pc_load with bus_sel=2, then go to T0.
REQ-019 T2 decode for JC SHALL assert pc_load with bus_sel=2 only if cf=1; for JZ, only if zf=1; both SHALL then go to T0.
REQ-020 T2 decode for OUT SHALL be: out_load with bus_sel=4, then go to T0; for NOP, no strobes, then go to T0.
REQ-021 T2 decode for HLT SHALL be: no strobes, then go to HALT.
REQ-022 T3 for LDA SHALL assert ram_rd and a_load with bus_sel=3, then go to T0.
REQ-023 T3 for ADD and SUB SHALL assert ram_rd and b_load with bus_sel=3, then go to T4.
REQ-024 T3 for STA SHALL assert ram_wr with bus_sel=4, then go to T0.
REQ-025 T4 for ADD and SUB SHALL assert a_load and flags_load with bus_sel=5, assert alu_sub only for SUB, then go to T0.
REQ-026 Instruction latency SHALL be 3 cycles (NOP, LDI, jumps, OUT), 4 cycles (LDA, STA) or 5 cycles (ADD, SUB).
REQ-027 HALT SHALL hold indefinitely with halted=1, all strobes 0 and tstate=0, regardless of run; only rst exits HALT.
REQ-028 run SHALL be sampled only in T0; deasserting run mid-instruction SHALL NOT stall or abort the instruction.
REQ-029 Conditional jumps SHALL use zf and cf as sampled in T2, i.e. flags written by a prior instruction's T4.
REQ-030 At most one bus_sel source SHALL be active per cycle, and ram_rd and ram_wr SHALL never both be 1.

Reset
REQ-031 While rst=1, asynchronously, state SHALL be T0, halted=0, tstate=0, and all strobes and bus_sel SHALL be 0 (run gating applies at release).
REQ-032 Assertion of rst in any T-state or in HALT SHALL abort the instruction immediately, with no further strobes issued.

Verification
REQ-033 Reset then run=1, opcode=5 (LDI): tstate 0,1,2,0; mar_load@T0; ir_load and pc_inc@T1; a_load with bus_sel=2@T2.
REQ-034 Opcode=2 (ADD): five cycles; b_load with bus_sel=3@T3; a_load, flags_load with bus_sel=5 and alu_sub=0@T4; for opcode=3, alu_sub=1@T4.
REQ-035 Opcode=8 (JZ) with zf=0: no pc_load@T2; repeat with zf=1: pc_load=1@T2; both return to T0 after 3 cycles.
REQ-036 Opcode=F (HLT): halted=1 from the cycle after T2 and held for 20+ cycles with run toggling; rst clears halted=0 and tstate=0.
REQ-037 run=0 at reset release: tstate stays 0 with no strobes; drop run during an ADD at T3: the ADD completes T4, then the block holds in T0.
REQ-038 Assert rst asynchronously mid-T3 of STA: ram_wr falls with no clock edge; the block restarts at T0 after release.
